// File: rtl/alu_responder.sv
// alu_responder: responder end of the controller/ALU operand interface.
// Accepts (a, b, op) on a valid/ready request handshake and returns
// (result, flag) on a valid/ready response handshake. Single-cycle ops
// answer one cycle after acceptance; MUL iterates shift-add over WIDTH cycles.
// Optional feature macro: ALU_RESPONDER_OPCOUNT_EN adds a saturating 8-bit
// response-handshake counter on output op_count.
module alu_responder #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
`ifdef ALU_RESPONDER_OPCOUNT_EN
    output logic [7:0]       op_count,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    localparam int AW = 2 * WIDTH;      // full product width
    localparam int SW = 2 * WIDTH + 8;  // room for a shift of up to 7
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic [2:0]       op_r, op_nxt_s;
    logic [AW-1:0]    acc_r, acc_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] result_r, result_nxt_s;
    logic             flag_r, flag_nxt_s;
    logic             rsp_valid_r, rsp_valid_nxt_s;
    logic             busy_r;

    logic [WIDTH:0]   sum_s;
    logic [SW-1:0]    shl_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_flag_s;
    logic [AW-1:0]    addend_s;
    logic [AW-1:0]    acc_sum_s;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // Single-cycle ALU evaluated on the operands presented in the accept cycle
    always_comb begin
        sum_s      = {1'b0, a} + {1'b0, b};
        shl_s      = SW'(a) << b[2:0];
        alu_res_s  = {WIDTH{1'b0}};
        alu_flag_s = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_s  = sum_s[WIDTH-1:0];
                alu_flag_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                alu_res_s  = a - b;
                alu_flag_s = (a < b);
            end
            OP_AND: begin
                alu_res_s  = a & b;
                alu_flag_s = is_zero(a & b);
            end
            OP_OR: begin
                alu_res_s  = a | b;
                alu_flag_s = is_zero(a | b);
            end
            OP_XOR: begin
                alu_res_s  = a ^ b;
                alu_flag_s = is_zero(a ^ b);
            end
            OP_NOT: begin
                alu_res_s  = ~a;
                alu_flag_s = is_zero(~a);
            end
            OP_SHL: begin
                alu_res_s  = shl_s[WIDTH-1:0];
                alu_flag_s = |shl_s[SW-1:WIDTH];
            end
            default: begin
                alu_res_s  = {WIDTH{1'b0}};
                alu_flag_s = 1'b0;
            end
        endcase
    end

    // One shift-add multiply step from the latched operands
    always_comb begin
        if (b_r[cnt_r]) begin
            addend_s = AW'(a_r) << cnt_r;
        end else begin
            addend_s = {AW{1'b0}};
        end
        acc_sum_s = acc_r + addend_s;
    end

    // Next-state and next-datapath logic for the request/response FSM
    always_comb begin
        state_nxt_s     = state_r;
        a_nxt_s         = a_r;
        b_nxt_s         = b_r;
        op_nxt_s        = op_r;
        acc_nxt_s       = acc_r;
        cnt_nxt_s       = cnt_r;
        result_nxt_s    = result_r;
        flag_nxt_s      = flag_r;
        rsp_valid_nxt_s = rsp_valid_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    a_nxt_s  = a;
                    b_nxt_s  = b;
                    op_nxt_s = op;
                    if (op == OP_MUL) begin
                        acc_nxt_s   = {AW{1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = EXEC;
                    end else begin
                        result_nxt_s    = alu_res_s;
                        flag_nxt_s      = alu_flag_s;
                        rsp_valid_nxt_s = 1'b1;
                        state_nxt_s     = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (op_r == OP_MUL) begin
                    acc_nxt_s = acc_sum_s;
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                    if (cnt_r == CNT_LAST) begin
                        result_nxt_s    = acc_sum_s[WIDTH-1:0];
                        flag_nxt_s      = |acc_sum_s[AW-1:WIDTH];
                        rsp_valid_nxt_s = 1'b1;
                        state_nxt_s     = DONE;
                    end else begin
                        state_nxt_s = EXEC;
                    end
                end else begin
                    // Only MUL may iterate; anything else is abandoned
                    state_nxt_s = IDLE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                rsp_valid_nxt_s = 1'b0;
                state_nxt_s     = IDLE;
            end
        endcase
    end

    // State, operand and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 3'd0;
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            flag_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            op_r        <= op_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            result_r    <= result_nxt_s;
            flag_r      <= flag_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

`ifdef ALU_RESPONDER_OPCOUNT_EN
    logic [7:0] op_count_r;

    // Saturating count of completed response handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_r <= 8'd0;
        end else if (rsp_valid_r && rsp_ready && (op_count_r != 8'd255)) begin
            op_count_r <= op_count_r + 8'd1;
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign op_count = op_count_r;
`endif

    // req_ready is withheld while reset is asserted even if already in IDLE
    assign req_ready = (state_r == IDLE) && !reset;
    assign rsp_valid = rsp_valid_r;
    assign result    = result_r;
    assign flag      = flag_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder (WIDTH=7): directed vector table,
// hand-written multi-cycle sequences and randomized transactions checked
// against an integer-arithmetic reference model.
module tb_alu_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] a;
    logic [6:0] b;
    logic [2:0] op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [6:0] result;
    logic       flag;
    logic       busy;
`ifdef ALU_RESPONDER_OPCOUNT_EN
    logic [7:0] op_count;
`endif

    int nvec = 0;
    int nerr = 0;

    alu_responder #(.WIDTH(7), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .flag      (flag),
`ifdef ALU_RESPONDER_OPCOUNT_EN
        .op_count  (op_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] va;
        logic [6:0] vb;
        logic [2:0] vop;
        logic [6:0] exp_r;
        logic       exp_f;
        int         exp_lat;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 128
    function automatic void ref_alu(input int ua, input int ub, input int uop,
                                    output logic [6:0] r, output logic f);
        int v;
        case (uop)
            0: begin v = ua + ub;                 r = 7'(v % 128); f = (v >= 128); end
            1: begin v = (ua - ub + 128) % 128;   r = 7'(v);       f = (ua < ub); end
            2: begin v = ua & ub;                 r = 7'(v);       f = (v == 0); end
            3: begin v = ua | ub;                 r = 7'(v);       f = (v == 0); end
            4: begin v = ua ^ ub;                 r = 7'(v);       f = (v == 0); end
            5: begin v = 127 - ua;                r = 7'(v);       f = (v == 0); end
            6: begin v = ua * ub;                 r = 7'(v % 128); f = (v >= 128); end
            default: begin v = ua * (1 << (ub % 8)); r = 7'(v % 128); f = (v >= 128); end
        endcase
    endfunction

    // Full transaction: wait ready, request, scramble inputs, time response, hold, handshake
    task automatic run_txn(input logic [6:0] ta, input logic [6:0] tb_v, input logic [2:0] top,
                           input int hold, output int lat, output logic [6:0] r, output logic f);
        int w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        a = ta;
        b = tb_v;
        op = top;
        step();
        req_valid = 1'b0;
        a = 7'($urandom);
        b = 7'($urandom);
        op = 3'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
            a = 7'($urandom);
            b = 7'($urandom);
        end
        r = result;
        f = flag;
        for (int i = 0; i < hold; i++) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    vec_t       tbl[$];
    int         lat;
    logic [6:0] r;
    logic       f;
    logic [6:0] er;
    logic       ef;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        a = 7'd0;
        b = 7'd0;
        op = 3'd0;

        tbl.push_back('{7'd100, 7'd50,  3'd0, 7'd22,  1'b1, 1});
        tbl.push_back('{7'd127, 7'd1,   3'd0, 7'd0,   1'b1, 1});
        tbl.push_back('{7'd5,   7'd9,   3'd1, 7'd124, 1'b1, 1});
        tbl.push_back('{7'd9,   7'd5,   3'd1, 7'd4,   1'b0, 1});
        tbl.push_back('{7'd0,   7'd0,   3'd1, 7'd0,   1'b0, 1});
        tbl.push_back('{7'h55,  7'h2A,  3'd2, 7'd0,   1'b1, 1});
        tbl.push_back('{7'h55,  7'h2A,  3'd3, 7'd127, 1'b0, 1});
        tbl.push_back('{7'h7F,  7'h7F,  3'd4, 7'd0,   1'b1, 1});
        tbl.push_back('{7'h7F,  7'h00,  3'd5, 7'd0,   1'b1, 1});
        tbl.push_back('{7'h00,  7'h00,  3'd5, 7'd127, 1'b0, 1});
        tbl.push_back('{7'd12,  7'd11,  3'd6, 7'd4,   1'b1, 8});
        tbl.push_back('{7'd3,   7'd5,   3'd6, 7'd15,  1'b0, 8});
        tbl.push_back('{7'd127, 7'd127, 3'd6, 7'd1,   1'b1, 8});
        tbl.push_back('{7'd3,   7'd7,   3'd7, 7'd0,   1'b1, 1});
        tbl.push_back('{7'h41,  7'd1,   3'd7, 7'd2,   1'b1, 1});
        tbl.push_back('{7'd1,   7'd14,  3'd7, 7'd64,  1'b0, 1});

        // Reset state, sampled while reset is still asserted
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_flag",      32'(flag),      32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // rsp_ready with no response pending changes nothing
        rsp_ready = 1'b1;
        step();
        step();
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rsp_ready_busy",  32'(busy),      32'd0);

        // Directed table
        foreach (tbl[i]) begin
            run_txn(tbl[i].va, tbl[i].vb, tbl[i].vop, 0, lat, r, f);
            chk($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].exp_r));
            chk($sformatf("tbl%0d_flag", i),   32'(f), 32'(tbl[i].exp_f));
            chk($sformatf("tbl%0d_lat", i),    32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_drop", i),   32'(rsp_valid), 32'd0);
        end

        // MUL: busy right after acceptance, no response before 8 cycles
        req_valid = 1'b1;
        a = 7'd12;
        b = 7'd11;
        op = 3'd6;
        step();
        req_valid = 1'b0;
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("mul_not_yet", 32'(rsp_valid), 32'd0);
        step();
        chk("mul_valid_t8", 32'(rsp_valid), 32'd1);
        chk("mul_result", 32'(result), 32'd4);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // AND with response back-pressured for 5 cycles
        req_valid = 1'b1;
        a = 7'h55;
        b = 7'h2A;
        op = 3'd2;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i),  32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_result", i), 32'(result),    32'd0);
            chk($sformatf("stall%0d_flag", i),   32'(flag),      32'd1);
            chk($sformatf("stall%0d_ready", i),  32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("stall_drop_valid", 32'(rsp_valid), 32'd0);
        chk("stall_req_ready",  32'(req_ready), 32'd1);
        chk("stall_hold_flag",  32'(flag),      32'd1);

        // Reset three cycles into MUL 127*127 aborts the transaction
        req_valid = 1'b1;
        a = 7'd127;
        b = 7'd127;
        op = 3'd6;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_result",    32'(result),    32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        run_txn(7'd1, 7'd1, 3'd0, 0, lat, r, f);
        chk("abort_add_result", 32'(r), 32'd2);
        chk("abort_add_flag",   32'(f), 32'd0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [6:0] ra;
            logic [6:0] rb;
            logic [2:0] rop;
            ra  = 7'($urandom);
            rb  = 7'($urandom);
            rop = 3'($urandom);
            ref_alu(int'(ra), int'(rb), int'(rop), er, ef);
            run_txn(ra, rb, rop, int'($urandom_range(0, 3)), lat, r, f);
            chk($sformatf("rnd%0d_op%0d_result", i, rop), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_op%0d_flag", i, rop),   32'(f), 32'(ef));
            chk($sformatf("rnd%0d_op%0d_lat", i, rop),    32'(lat), (rop == 3'd6) ? 32'd8 : 32'd1);
        end

`ifdef ALU_RESPONDER_OPCOUNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("cnt_reset", 32'(op_count), 32'd0);
        req_valid = 1'b1;
        a = 7'd1;
        b = 7'd2;
        op = 3'd0;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("cnt_held_done", 32'(op_count), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("cnt_one", 32'(op_count), 32'd1);
        for (int i = 0; i < 260; i++) run_txn(7'd1, 7'd1, 3'd0, 0, lat, r, f);
        chk("cnt_saturate", 32'(op_count), 32'd255);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("cnt_reset2", 32'(op_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
